// File: rtl/register_file_if.sv
// Bus bundle for the RV32I register file: two read index/data pairs and one write port.
interface register_file_if;
    logic [4:0]  read_register1;
    logic [4:0]  read_register2;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    modport master (
        output read_register1,
        output read_register2,
        output write_register,
        output write_data,
        output reg_write,
        input  read_data1,
        input  read_data2
    );

    modport slave (
        input  read_register1,
        input  read_register2,
        input  write_register,
        input  write_data,
        input  reg_write,
        output read_data1,
        output read_data2
    );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit RV32I register file: two combinational read ports, one synchronous write port.
// x0 has no storage and always reads zero; there is no write-to-read bypass.
module register_file (
    input  logic          clk,
    input  logic          reset,
    register_file_if.slave bus
);

    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    // A write to x0 matches no entry and is dropped; reg_write low leaves every entry untouched.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (bus.reg_write && (bus.write_register == 5'(i))) begin
                regs_d[i] = bus.write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bus.read_data1 = '0;
        bus.read_data2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (bus.read_register1 == 5'(i)) begin
                bus.read_data1 = regs_q[i];
            end
            if (bus.read_register2 == 5'(i)) begin
                bus.read_data2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file with hand-computed expected values.
module tb_register_file;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    register_file_if bus ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [31:0] e1, input logic [31:0] e2);
        bus.read_register1 = r1;
        bus.read_register2 = r2;
        #1;
        check({tag, "_rd1"}, bus.read_data1, e1);
        check({tag, "_rd2"}, bus.read_data2, e2);
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        bus.reg_write      = 1'b1;
        bus.write_register = idx;
        bus.write_data     = data;
        tick();
        bus.reg_write      = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.read_register1 = '0;
        bus.read_register2 = '0;
        bus.write_register = '0;
        bus.write_data     = '0;
        bus.reg_write      = 1'b0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            read_chk("init_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0);
        end

        // Reset clears a written register
        write_reg(5'd5, 32'hDEADBEEF);
        read_chk("x5_written", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_chk("x5_after_reset", 5'd5, 5'd0, 32'h0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            read_chk("reset_sweep", 5'(i), 5'(i), 32'h0, 32'h0);
        end

        // Basic write/read
        write_reg(5'd2, 32'd24);
        read_chk("basic", 5'd2, 5'd1, 32'd24, 32'h0);

        // Write-enable gating, including input wiggles with reg_write low
        bus.reg_write      = 1'b0;
        bus.write_register = 5'd3;
        bus.write_data     = 32'h12345678;
        tick();
        read_chk("we_gate", 5'd3, 5'd3, 32'h0, 32'h0);
        bus.write_register = 5'd2;
        bus.write_data     = 32'hCAFEF00D;
        tick();
        read_chk("we_gate_x2", 5'd2, 5'd2, 32'd24, 32'd24);

        // x0 hardwired
        write_reg(5'd0, 32'hFFFFFFFF);
        read_chk("x0", 5'd0, 5'd0, 32'h0, 32'h0);

        // Same-cycle read/write: old value before the edge, new after
        write_reg(5'd7, 32'd10);
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd7;
        bus.write_data     = 32'd99;
        read_chk("rw_before", 5'd7, 5'd2, 32'd10, 32'd24);
        tick();
        bus.reg_write = 1'b0;
        read_chk("rw_after", 5'd7, 5'd7, 32'd99, 32'd99);

        // Full sweep x1..x31 = i*3
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i * 3));
            read_chk("sweep", 5'(i), 5'(i), 32'(i * 3), 32'(i * 3));
        end
        read_chk("sweep_mix", 5'd31, 5'd1, 32'd93, 32'd3);

        // Reset wins over simultaneous write
        reset              = 1'b1;
        bus.reg_write      = 1'b1;
        bus.write_register = 5'd4;
        bus.write_data     = 32'd55;
        tick();
        read_chk("rst_prio", 5'd4, 5'd31, 32'h0, 32'h0);
        // Reset held for a second edge still holds everything at zero
        bus.write_register = 5'd9;
        tick();
        read_chk("rst_hold", 5'd9, 5'd4, 32'h0, 32'h0);
        reset         = 1'b0;
        bus.reg_write = 1'b0;

        // Write works again after reset release
        write_reg(5'd31, 32'hA5A5_5A5A);
        read_chk("post_reset", 5'd31, 5'd30, 32'hA5A5_5A5A, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

32 x 32-bit general-purpose register file for the RV32I datapath: two combinational read ports feeding the ALU operands and one synchronous write port driven by writeback. Register x0 is hardwired to zero. The block sits between instruction decode, which supplies the register indices, and the execute and writeback stages.

## Interface

Reset is synchronous and active-high on one clock (clk), as fixed for this block.

Parameters:
- none; the architecture fixes 32 registers x 32 bits.

Ports:
- clk  input  1  single clock; all state changes occur on its rising edge
- reset  input  1  synchronous, active-high; clears all registers
- read_register1  input  5  index of rs1
- read_register2  input  5  index of rs2
- write_register  input  5  index of rd
- write_data  input  32  data to write into rd
- reg_write  input  1  write enable for rd
- read_data1  output  32  contents of register read_register1
- read_data2  output  32  contents of register read_register2

## Operation

- Storage: registers x1..x31, 32 bits each. x0 has no storage.
- Read ports:
  - Purely combinational, with no clock involvement.
  - read_dataN = 0 when read_registerN == 0; otherwise it is the current stored value of that register.
  - Both ports are independent and may address the same register.
- Write:
  - On a rising clk edge with reset == 0 and reg_write == 1, write_data is stored into register write_register.
  - A write with write_register == 0 is discarded; x0 stays 0.
  - If reg_write == 0, no register changes, whatever is on write_register or write_data.
- Reset:
  - On a rising clk edge with reset == 1, x1..x31 all become 0.
  - Reset has priority over a simultaneous write; the write is dropped.
- No internal write-to-read bypass:
  - A read of the register being written in the same cycle returns the old value until the clock edge.
  - After the edge, the read returns the new value through the combinational path.
  - Forwarding, if needed, is handled outside this block.
- Contents before the first reset are unspecified (X in simulation). Verification must not depend on them.
- Inputs are never X-propagated into storage when reg_write == 0.

## Timing

- Read latency: 0 cycles (combinational, address to data).
- Write latency: 1 edge; new data is visible on the read ports immediately after the rising clk edge that commits it.
- Reset latency: 1 edge; after the reset edge, read_data1 and read_data2 are 0 for every index.
- Output reset value: 0 on both read ports, for any address, from the reset edge onward until a write occurs.
- Reset asserted mid-operation: it takes effect at the next rising edge regardless of reg_write. It holds all registers at 0 for every edge while asserted.
- Simultaneous events:
  - Reset and write on the same edge: reset wins.
  - Both ports reading the same register: both outputs are identical.
  - Read and write of the same register in one cycle: the read shows the old value before the edge and the new value after it.
- Changes on reg_write, write_register or write_data between edges have no effect on state.

## Test plan

- Reset clears: write x5 = 32'hDEADBEEF, then assert reset for 1 edge -> read_register1 = 5 gives read_data1 = 0; every index 0..31 reads 0 on both ports.
- Basic write/read: reg_write = 1, write_register = 2, write_data = 24, clock edge -> read_register1 = 2 gives read_data1 = 24; read_register2 = 1 gives read_data2 = 0.
- Write-enable gating: reg_write = 0, write_register = 3, write_data = 32'h12345678, clock edge -> x3 still reads 0.
- x0 hardwired: reg_write = 1, write_register = 0, write_data = 32'hFFFFFFFF, clock edge -> read_register1 = read_register2 = 0 gives both outputs 0.
- Same-cycle read/write: x7 = 10; drive write_register = 7, write_data = 99, reg_write = 1 with read_register1 = 7 -> read_data1 = 10 before the edge, 99 after it; read_register2 = 7 also shows 99.
- Reset priority and full sweep: write x1..x31 with values i*3, verifying each on both ports; then assert reset with reg_write = 1, write_register = 4, write_data = 55 -> x4 reads 0 after the edge.
